// File: rtl/decode_sequencer_if.sv
// decode_sequencer_if: fetch / execute / extension-unit signals of the decode sequencer.
// With DECODE_ILLEGAL_TRAP_EN defined the bundle also carries the illegal flag.
interface decode_sequencer_if #(
  parameter int unsigned ALUCTL_W = 10
) ();
  // fetch side
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instr;
  // execute side
  logic                out_valid;
  logic                out_ready;
  logic                out_regwe;
  logic                out_memwe;
  logic                out_rwmem;
  logic [3:0]          out_byteena;
  logic                out_isimm;
  logic [1:0]          out_immtype;
  logic                out_isbr;
  logic                out_isjal;
  logic                out_aluneg;
  logic [ALUCTL_W-1:0] out_alucontrol;
  logic                out_ext_timeout;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                illegal;
`endif
  // extension unit
  logic                ext_start;
  logic [2:0]          ext_sel;
  logic                ext_done;

  // Decoder view
  modport slave (
    input  in_valid, instr, out_ready, ext_done,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output illegal,
`endif
    output in_ready, out_valid, out_regwe, out_memwe, out_rwmem, out_byteena,
           out_isimm, out_immtype, out_isbr, out_isjal, out_aluneg,
           out_alucontrol, out_ext_timeout, ext_start, ext_sel
  );

  // Environment view (fetch + execute + extension unit)
  modport master (
    output in_valid, instr, out_ready, ext_done,
`ifdef DECODE_ILLEGAL_TRAP_EN
    input  illegal,
`endif
    input  in_ready, out_valid, out_regwe, out_memwe, out_rwmem, out_byteena,
           out_isimm, out_immtype, out_isbr, out_isjal, out_aluneg,
           out_alucontrol, out_ext_timeout, ext_start, ext_sel
  );
endinterface

// File: rtl/decode_sequencer.sv
// decode_sequencer: registered RV32 decoder that also sequences multi-cycle
// extension ops (issue, wait for done or timeout, then present the bundle).
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (illegal flag + sticky trap).
module decode_sequencer #(
  parameter int unsigned ALUCTL_W    = 10,
  parameter int unsigned NUM_EXT     = 8,
  parameter int unsigned EXT_TIMEOUT = 256
) (
  input logic               clk,
  input logic               rst,
  decode_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (EXT_TIMEOUT > 2) ? $clog2(EXT_TIMEOUT) : 1;

  localparam logic [4:0] OPC_R     = 5'b01100;
  localparam logic [4:0] OPC_OPI   = 5'b00100;
  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_STORE = 5'b01000;
  localparam logic [4:0] OPC_BR    = 5'b11000;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_JAL   = 5'b11011;
  localparam logic [4:0] OPC_EXT_R = 5'b00010;
  localparam logic [4:0] OPC_EXT_I = 5'b01010;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLD      = 3'd1,
    S_EXT_ISSUE = 3'd2,
    S_EXT_WAIT  = 3'd3,
    S_TRAP      = 3'd4
  } state_t;

  typedef struct packed {
    logic                regwe;
    logic                memwe;
    logic                rwmem;
    logic [3:0]          byteena;
    logic                isimm;
    logic [1:0]          immtype;
    logic                isbr;
    logic                isjal;
    logic                aluneg;
    logic [ALUCTL_W-1:0] alucontrol;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                illegal;
`endif
  } bundle_t;

  logic [4:0]       w_opcode;
  logic [2:0]       w_f3;
  logic             w_ext_opc;
  logic             w_ext_ok;
  logic             w_is_ext;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_unused;
  bundle_t          w_dec;

  state_t           r_state;
  bundle_t          r_bundle;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic             r_timeout;
  logic             r_ext_start;
  logic [2:0]       r_ext_sel;

  assign w_opcode  = bus.instr[6:2];
  assign w_f3      = bus.instr[14:12];
  assign w_ext_opc = (w_opcode == OPC_EXT_R) || (w_opcode == OPC_EXT_I);
  assign w_ext_ok  = (w_f3 != 3'd0) && (32'(w_f3) < NUM_EXT);
  assign w_is_ext  = w_ext_opc && w_ext_ok;
  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_unused  = &{1'b0, bus.instr[31], bus.instr[29:15], bus.instr[11:7], bus.instr[1:0]};

  // Instruction -> control bundle; anything unrecognised stays all-zero
  always_comb begin
    w_dec = '0;
    case (w_opcode)
      OPC_R: begin
        w_dec.regwe      = 1'b1;
        w_dec.aluneg     = bus.instr[30];
        w_dec.alucontrol = ALUCTL_W'(w_f3);
      end
      OPC_OPI: begin
        w_dec.regwe      = 1'b1;
        w_dec.isimm      = 1'b1;
        w_dec.alucontrol = ALUCTL_W'(w_f3);
      end
      OPC_LOAD: begin
        w_dec.regwe = 1'b1;
        w_dec.rwmem = 1'b1;
        w_dec.isimm = 1'b1;
      end
      OPC_STORE: begin
        w_dec.memwe   = 1'b1;
        w_dec.rwmem   = 1'b1;
        w_dec.isimm   = 1'b1;
        w_dec.immtype = 2'd1;
        case (w_f3)
          3'b000:  w_dec.byteena = 4'b0001;
          3'b001:  w_dec.byteena = 4'b0011;
          3'b010:  w_dec.byteena = 4'b1111;
          default: w_dec.byteena = 4'b0000;
        endcase
      end
      OPC_BR: begin
        w_dec.aluneg = 1'b1;
        w_dec.isbr   = 1'b1;
      end
      OPC_JALR: begin
        w_dec.isimm = 1'b1;
      end
      OPC_JAL: begin
        w_dec.isbr  = 1'b1;
        w_dec.isjal = 1'b1;
      end
      OPC_EXT_R, OPC_EXT_I: begin
        if (w_ext_ok) begin
          w_dec.isbr  = 1'b1;
          w_dec.isimm = (w_opcode == OPC_EXT_I);
          w_dec.regwe = (w_f3 == 3'd3);
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        else begin
          w_dec.illegal = 1'b1;
        end
`endif
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        w_dec.illegal = 1'b1;
`endif
      end
    endcase
  end

  // Accept when idle, or when the held bundle is being consumed this cycle
  always_comb begin
    w_in_ready = 1'b0;
    if (!rst) begin
      if (r_state == S_IDLE) begin
        w_in_ready = 1'b1;
      end else if (r_state == S_HOLD) begin
        w_in_ready = bus.out_ready;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (r_bundle.illegal) w_in_ready = 1'b0;
`endif
      end
    end
  end

  // Sequencer FSM with registered bundle, handshake and extension-unit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bundle    <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ext_start <= 1'b0;
      r_ext_sel   <= 3'd0;
    end else begin
      r_ext_start <= 1'b0;
      if (w_accept) begin
        r_bundle  <= w_dec;
        r_timeout <= 1'b0;
        if (w_is_ext) begin
          r_state     <= S_EXT_ISSUE;
          r_ext_start <= 1'b1;
          r_ext_sel   <= w_f3;
          r_out_valid <= 1'b0;
        end else begin
          r_state     <= S_HOLD;
          r_out_valid <= 1'b1;
        end
      end else begin
        case (r_state)
          S_HOLD: begin
            if (bus.out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= S_IDLE;
`ifdef DECODE_ILLEGAL_TRAP_EN
              if (r_bundle.illegal) r_state <= S_TRAP;
`endif
            end
          end
          S_EXT_ISSUE: begin
            r_state <= S_EXT_WAIT;
            r_cnt   <= '0;
          end
          S_EXT_WAIT: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (bus.ext_done) begin
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
              r_ext_sel   <= 3'd0;
            end else if (r_cnt == CNT_W'(EXT_TIMEOUT - 1)) begin
              // aborted op: present the bundle but never write the register file
              r_state        <= S_HOLD;
              r_out_valid    <= 1'b1;
              r_ext_sel      <= 3'd0;
              r_timeout      <= 1'b1;
              r_bundle.regwe <= 1'b0;
            end
          end
          S_IDLE, S_TRAP: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_regwe       = r_bundle.regwe;
  assign bus.out_memwe       = r_bundle.memwe;
  assign bus.out_rwmem       = r_bundle.rwmem;
  assign bus.out_byteena     = r_bundle.byteena;
  assign bus.out_isimm       = r_bundle.isimm;
  assign bus.out_immtype     = r_bundle.immtype;
  assign bus.out_isbr        = r_bundle.isbr;
  assign bus.out_isjal       = r_bundle.isjal;
  assign bus.out_aluneg      = r_bundle.aluneg;
  assign bus.out_alucontrol  = r_bundle.alucontrol;
  assign bus.out_ext_timeout = r_timeout;
  assign bus.ext_start       = r_ext_start;
  assign bus.ext_sel         = r_ext_sel;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign bus.illegal         = r_bundle.illegal;
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed stimulus with a transaction-level decode model
// and a per-cycle monitor comparing every presented bundle to the model.
module tb_decode_sequencer;

  localparam int unsigned ALUW = 10;
  localparam int unsigned NEXT = 8;
  localparam int unsigned TO   = 6;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic            regwe;
    logic            memwe;
    logic            rwmem;
    logic [3:0]      byteena;
    logic            isimm;
    logic [1:0]      immtype;
    logic            isbr;
    logic            isjal;
    logic            aluneg;
    logic [ALUW-1:0] alu;
    logic            tmo;
    logic            ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q[$];

  decode_sequencer_if #(.ALUCTL_W(ALUW)) bus ();

  decode_sequencer #(
    .ALUCTL_W   (ALUW),
    .NUM_EXT    (NEXT),
    .EXT_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // What the execute stage must see for an instruction, from the decode rules
  function automatic exp_t model(input logic [31:0] ins, input logic tmo);
    exp_t       e;
    logic [4:0] opc;
    logic [2:0] f3;
    logic       ext_ok;
    e      = '0;
    opc    = ins[6:2];
    f3     = ins[14:12];
    ext_ok = (f3 >= 3'd1) && (32'(f3) < NEXT);
    case (opc)
      5'b01100: begin e.regwe = 1'b1; e.aluneg = ins[30]; e.alu = ALUW'(f3); end
      5'b00100: begin e.regwe = 1'b1; e.isimm = 1'b1; e.alu = ALUW'(f3); end
      5'b00000: begin e.regwe = 1'b1; e.rwmem = 1'b1; e.isimm = 1'b1; end
      5'b01000: begin
        e.memwe = 1'b1; e.rwmem = 1'b1; e.isimm = 1'b1; e.immtype = 2'd1;
        // store of 2^f3 bytes enables that many low lanes
        if (f3 < 3'd3) e.byteena = 4'((1 << (1 << f3)) - 1);
      end
      5'b11000: begin e.aluneg = 1'b1; e.isbr = 1'b1; end
      5'b11001: e.isimm = 1'b1;
      5'b11011: begin e.isbr = 1'b1; e.isjal = 1'b1; end
      5'b00010, 5'b01010: begin
        if (ext_ok) begin
          e.isbr  = 1'b1;
          e.isimm = (opc == 5'b01010);
          e.regwe = (f3 == 3'd3);
        end else begin
          e.ill = ILL_EN;
        end
      end
      default: e.ill = ILL_EN;
    endcase
    if (tmo) begin
      e.tmo   = 1'b1;
      e.regwe = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.regwe   = bus.out_regwe;
    a.memwe   = bus.out_memwe;
    a.rwmem   = bus.out_rwmem;
    a.byteena = bus.out_byteena;
    a.isimm   = bus.out_isimm;
    a.immtype = bus.out_immtype;
    a.isbr    = bus.out_isbr;
    a.isjal   = bus.out_isjal;
    a.aluneg  = bus.out_aluneg;
    a.alu     = bus.out_alucontrol;
    a.tmo     = bus.out_ext_timeout;
`ifdef DECODE_ILLEGAL_TRAP_EN
    a.ill     = bus.illegal;
`else
    a.ill     = 1'b0;
`endif
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string nm, input exp_t act, input exp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every cycle a bundle is presented it must equal the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        chk_b("bundle", actual(), q[0]);
        if (bus.out_ready) q.delete(0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and wait (bounded) for the handshake; in_valid stays high
  task automatic send(input logic [31:0] ins, input logic tmo, output int waits);
    bus.instr    = ins;
    bus.in_valid = 1'b1;
    waits        = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
    end
    chk("accept_within_bound", 32'(waits < 20), 32'd1);
    if (waits < 20) q.push_back(model(ins, tmo));
    step();
  endtask

  // Extension op with ext_done raised on wait cycle done_at (0 = never)
  task automatic ext_op(input logic [31:0] ins, input int done_at, input logic exp_regwe);
    int         w;
    int         n;
    logic       tmo;
    logic [2:0] sel;
    tmo = (done_at == 0) || (done_at > int'(TO));
    sel = ins[14:12];
    send(ins, tmo, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ext_start_issue", 32'(bus.ext_start), 32'd1);
    chk("ext_sel_issue", 32'(bus.ext_sel), 32'(sel));
    chk("in_ready_issue", 32'(bus.in_ready), 32'd0);
    chk("out_valid_issue", 32'(bus.out_valid), 32'd0);
    step();
    n = tmo ? int'(TO) : done_at;
    for (int i = 1; i <= n; i++) begin
      if (i == done_at) bus.ext_done = 1'b1;
      @(negedge clk);
      chk("ext_start_wait", 32'(bus.ext_start), 32'd0);
      chk("ext_sel_wait", 32'(bus.ext_sel), 32'(sel));
      chk("in_ready_wait", 32'(bus.in_ready), 32'd0);
      chk("out_valid_wait", 32'(bus.out_valid), 32'd0);
      step();
      bus.ext_done = 1'b0;
    end
    @(negedge clk);
    chk("out_valid_after_ext", 32'(bus.out_valid), 32'd1);
    chk("ext_timeout_flag", 32'(bus.out_ext_timeout), 32'(tmo));
    chk("ext_regwe", 32'(bus.out_regwe), 32'(exp_regwe));
    step();
  endtask

  logic [31:0] stream [12];

  initial begin
    int w;
    stream[0]  = 32'h0000A083;  // lw
    stream[1]  = 32'h00208023;  // sb
    stream[2]  = 32'h00209023;  // sh
    stream[3]  = 32'h0020A223;  // sw
    stream[4]  = 32'h0020B023;  // store f3=3
    stream[5]  = 32'h0020A093;  // slti-style op-imm f3=2
    stream[6]  = 32'h00000063;  // beq
    stream[7]  = 32'h00008067;  // jalr
    stream[8]  = 32'h0000006F;  // jal
    stream[9]  = 32'h4020D033;  // sra
    stream[10] = 32'h0000000B;  // ext-R f3=0 -> plain bundle
    stream[11] = 32'h00108093;  // addi

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'd0;
    bus.out_ready = 1'b1;
    bus.ext_done  = 1'b0;

    // reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({bus.out_valid, bus.out_regwe, bus.out_memwe, bus.out_rwmem,
                            bus.out_byteena, bus.out_isimm, bus.out_immtype, bus.out_isbr,
                            bus.out_isjal, bus.out_aluneg, bus.out_alucontrol,
                            bus.out_ext_timeout, bus.ext_start, bus.ext_sel}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    step();

    // SW then SUB back-to-back
    send(32'h0020A223, 1'b0, w);
    bus.instr = 32'h40208033;
    @(negedge clk);
    chk("sw_out_valid", 32'(bus.out_valid), 32'd1);
    chk("sw_memwe", 32'(bus.out_memwe), 32'd1);
    chk("sw_byteena", 32'(bus.out_byteena), 32'hF);
    chk("sw_immtype", 32'(bus.out_immtype), 32'd1);
    chk("sw_in_ready", 32'(bus.in_ready), 32'd1);
    q.push_back(model(32'h40208033, 1'b0));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sub_out_valid", 32'(bus.out_valid), 32'd1);
    chk("sub_aluneg", 32'(bus.out_aluneg), 32'd1);
    chk("sub_alucontrol", 32'(bus.out_alucontrol), 32'd0);
    chk("sub_regwe", 32'(bus.out_regwe), 32'd1);
    step();

    // streaming non-ext ops, one per cycle
    foreach (stream[i]) begin
      send(stream[i], 1'b0, w);
      chk("no_bubble", 32'(w), 32'd0);
    end
    bus.in_valid = 1'b0;
    step();

    // extension ops: done mid-wait, timeout, done on the timeout cycle, done at first cycle
    ext_op(32'h0000300B, 5, 1'b1);
    ext_op(32'h0000102B, 0, 1'b0);
    send(32'h00108093, 1'b0, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("timeout_cleared_on_load", 32'(bus.out_ext_timeout), 32'd0);
    step();
    ext_op(32'h0000102B, int'(TO), 1'b0);
    ext_op(32'h0000302B, 1, 1'b1);
    ext_op(32'h0000300B, 0, 1'b0);

    // stall in HOLD for three cycles with the next instr waiting
    bus.out_ready = 1'b0;
    send(32'h0020A223, 1'b0, w);
    bus.instr = 32'h00108093;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      step();
    end
    bus.out_ready = 1'b1;
    send(32'h00108093, 1'b0, w);
    chk("stall_release_wait", 32'(w), 32'd0);
    bus.in_valid = 1'b0;
    step();

    // reset in the middle of an extension wait
    send(32'h0000300B, 1'b0, w);
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midwait_rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("midwait_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midwait_rst_ext_start", 32'(bus.ext_start), 32'd0);
    chk("midwait_rst_ext_sel", 32'(bus.ext_sel), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("after_rst_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.ext_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stray_done_out_valid", 32'(bus.out_valid), 32'd0);
      chk("stray_done_ext_start", 32'(bus.ext_start), 32'd0);
      chk("stray_done_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.ext_done = 1'b0;
    end

    // unlisted opcode 0x7F
    send(32'h0000007F, 1'b0, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("op7f_out_valid", 32'(bus.out_valid), 32'd1);
    chk("op7f_regwe", 32'(bus.out_regwe), 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("op7f_illegal", 32'(bus.illegal), 32'd1);
`endif
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("op7f_in_ready", 32'(bus.in_ready), 32'(!ILL_EN));
      step();
    end
`ifndef DECODE_ILLEGAL_TRAP_EN
    send(32'h0020A093, 1'b0, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flow_after_op7f", 32'(bus.out_valid), 32'd1);
    step();
`endif

    step();
    chk("expectations_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Run-time bound
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
